interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Sits between the interrupt controller's next_interrupt output and the 12-bit CPU core.
- Decides when a pending interrupt is taken: global enable, instruction boundary, and priority versus the currently serviced level.
- Hands the CPU a vector and captures the return PC.
- Issues a one-cycle dismiss for the taken line back to the controller; keeps a nesting stack of {level, PC} for return-from-interrupt.

Parameters:
- DEPTH, 4, nesting stack entries (1..8).
- VEC_BASE, 12'o0100, vector for interrupt id 0.
- VEC_SHIFT, 1, vector = VEC_BASE + (id << VEC_SHIFT), computed mod 4096.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- next_interrupt  in  12  highest-priority pending id from controller; 12'o7777 = none
- boundary  in  1  CPU at instruction boundary this cycle
- ie_set  in  1  set global interrupt enable
- ie_clear  in  1  clear global interrupt enable
- cpu_ack  in  1  CPU accepts irq_take this cycle
- pc_in  in  12  PC to save, sampled on cpu_ack
- ret_strobe  in  1  CPU executes return-from-interrupt
- irq_take  out  1  request CPU to vector
- irq_vector  out  12  target address, valid while irq_take
- ctl_dismiss  out  1  dismiss strobe to controller
- ctl_data  out  12  id to dismiss, valid with ctl_dismiss
- ret_valid  out  1  one-cycle pulse, ret_pc valid
- ret_pc  out  12  restored PC
- ie  out  1  global enable
- level  out  12  id being serviced; 12'o7777 = none
- depth  out  3  stack occupancy
- err  out  1  sticky: return with empty stack, or return outside IDLE

Behaviour:
- Reset values: state IDLE, ie=0, level=7777, depth=0, err=0, all strobes 0, irq_vector=0, ctl_data=0, ret_pc=0.
- Reset mid-operation aborts any request; the stack is discarded.
- pending = (next_interrupt != 7777) & ie & (next_interrupt < level) & (depth < DEPTH). Lower id means higher priority.
- ie: ie_set and ie_clear in the same cycle gives ie_clear precedence. State-machine writes to ie override both.
- States: IDLE, REQ, DISMISS.
- IDLE -> REQ:
  - Condition: pending & boundary.
  - Latch id = next_interrupt.
  - Next cycle: irq_take=1, irq_vector = VEC_BASE + (id << VEC_SHIFT).
- REQ:
  - irq_take and irq_vector are held until exit; id stays frozen even if next_interrupt changes.
  - On cpu_ack:
    - push {level, pc_in}; depth+1
    - level <= id; ie <= 0
    - go to DISMISS
  - Withdraw: ie_clear without cpu_ack returns to IDLE, irq_take=0, stack untouched.
  - cpu_ack with ie_clear in the same cycle: the ack wins.
- DISMISS:
  - ctl_dismiss=1 and ctl_data=id for exactly one cycle.
  - Then IDLE.
  - Latency: boundary-qualified pending to irq_take is 1 cycle; cpu_ack to ctl_dismiss is 1 cycle.
- Return (honoured only in IDLE):
  - With depth>0: pop; ret_pc = popped PC; level = popped level; ie <= 1; ret_valid pulses the next cycle; depth-1.
  - With depth==0: err <= 1, no other effect.
  - In REQ or DISMISS: ignored, err <= 1.
  - A return and a pending take in the same IDLE cycle: return first; the take is re-evaluated next cycle with the restored level.
- Stack full (depth==DEPTH): no take; nesting is blocked until a return.
- Pointer arithmetic saturates and never wraps.
- Irq_vector arithmetic is 12-bit and wraps mod 4096.
- Equal priority (next_interrupt == level) is never taken.

Test Plan:
- After reset, ie_set, next_interrupt=2, boundary=1 -> next cycle irq_take=1, irq_vector=12'o0104. cpu_ack with pc_in=12'o1234 -> next cycle ctl_dismiss=1, ctl_data=2, level=2, ie=0, depth=1.
- In service of id 2 with ie=1: next_interrupt=3 -> no take. next_interrupt=0 -> take, vector 12'o0100, depth=2. ret_strobe -> ret_valid, ret_pc=saved PC, level=2.
- DEPTH=2 full: next_interrupt=0, ie=1, boundary -> irq_take stays 0. One return -> take proceeds the following boundary.
- In REQ: ie_clear without ack -> irq_take drops, depth unchanged. Repeat with cpu_ack and ie_clear together -> taken normally.
- ret_strobe with depth=0 -> err=1, ret_valid=0. Assert rst in REQ -> all outputs at reset values next cycle.
- next_interrupt=7777 with ie=1 and boundary for 20 cycles -> irq_take never asserts.

Source files
------------

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer_if
// Purpose  : Controller/CPU-facing signal bundle of the interrupt sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface interrupt_sequencer_if;
  logic [11:0] next_interrupt;
  logic        boundary;
  logic        ie_set;
  logic        ie_clear;
  logic        cpu_ack;
  logic [11:0] pc_in;
  logic        ret_strobe;
  logic        irq_take;
  logic [11:0] irq_vector;
  logic        ctl_dismiss;
  logic [11:0] ctl_data;
  logic        ret_valid;
  logic [11:0] ret_pc;
  logic        ie;
  logic [11:0] level;
  logic [2:0]  depth;
  logic        err;

  modport slave (
    input  next_interrupt, boundary, ie_set, ie_clear, cpu_ack, pc_in, ret_strobe,
    output irq_take, irq_vector, ctl_dismiss, ctl_data, ret_valid, ret_pc,
           ie, level, depth, err
  );

  modport master (
    output next_interrupt, boundary, ie_set, ie_clear, cpu_ack, pc_in, ret_strobe,
    input  irq_take, irq_vector, ctl_dismiss, ctl_data, ret_valid, ret_pc,
           ie, level, depth, err
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_sequencer
// Purpose  : Takes prioritised interrupts at instruction boundaries, vectors
//            the CPU, dismisses the line and keeps a {level, PC} nesting stack.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_sequencer #(
  parameter int          DEPTH     = 4,
  parameter logic [11:0] VEC_BASE  = 12'o0100,
  parameter int          VEC_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  localparam int          C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          C_SLOTS = 1 << C_AW;
  localparam logic [3:0]  C_DEPTH = 4'(DEPTH);
  localparam logic [11:0] C_NONE  = 12'o7777;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISMISS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_ie;
  logic [11:0]     r_level;
  logic [11:0]     r_id;
  logic [11:0]     r_vector;
  logic [11:0]     r_ret_pc;
  logic            r_ret_valid;
  logic            r_err;
  logic [3:0]      r_cnt;
  logic [11:0]     r_stk_lvl [C_SLOTS];
  logic [11:0]     r_stk_pc  [C_SLOTS];

  logic            w_pending;
  logic            w_take;
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;
  logic [11:0]     w_vec;
  logic [C_AW-1:0] w_push_idx;
  logic [C_AW-1:0] w_pop_idx;

  // Lower id means higher priority; equal priority never preempts.
  assign w_pending = (bus.next_interrupt != C_NONE) && r_ie &&
                     (bus.next_interrupt < r_level) && (r_cnt < C_DEPTH);
  assign w_vec      = VEC_BASE + (bus.next_interrupt << VEC_SHIFT);
  assign w_push_idx = r_cnt[C_AW-1:0];
  assign w_pop_idx  = w_push_idx - C_AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A return pre-empts a take; the take is re-evaluated at the restored level.
        if (bus.ret_strobe) begin
          if (r_cnt != 4'd0) begin
            w_pop = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end else if (w_pending && bus.boundary) begin
          w_take      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_err_set = bus.ret_strobe;
        if (bus.cpu_ack) begin
          w_push      = 1'b1;
          w_state_nxt = S_DISMISS;
        end else if (bus.ie_clear) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DISMISS: begin
        w_err_set   = bus.ret_strobe;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie        <= 1'b0;
      r_level     <= C_NONE;
      r_id        <= 12'd0;
      r_vector    <= 12'd0;
      r_ret_pc    <= 12'd0;
      r_ret_valid <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= 4'd0;
    end else begin
      r_ret_valid <= w_pop;
      if (w_take) begin
        r_id     <= bus.next_interrupt;
        r_vector <= w_vec;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_push) begin
        r_level <= r_id;
        r_ie    <= 1'b0;
        if (r_cnt < C_DEPTH) begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (w_pop) begin
        r_level  <= r_stk_lvl[w_pop_idx];
        r_ret_pc <= r_stk_pc[w_pop_idx];
        r_ie     <= 1'b1;
        r_cnt    <= r_cnt - 4'd1;
      end else if (bus.ie_clear) begin
        r_ie <= 1'b0;
      end else if (bus.ie_set) begin
        r_ie <= 1'b1;
      end
    end
  end

  // Stack contents need no reset: occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (w_push && (r_cnt < C_DEPTH)) begin
      r_stk_lvl[w_push_idx] <= r_level;
      r_stk_pc[w_push_idx]  <= bus.pc_in;
    end
  end

  assign bus.irq_take    = (r_state == S_REQ);
  assign bus.irq_vector  = r_vector;
  assign bus.ctl_dismiss = (r_state == S_DISMISS);
  assign bus.ctl_data    = r_id;
  assign bus.ret_valid   = r_ret_valid;
  assign bus.ret_pc      = r_ret_pc;
  assign bus.ie          = r_ie;
  assign bus.level       = r_level;
  // A full 8-deep stack reports 7 on the 3-bit occupancy output.
  assign bus.depth       = (r_cnt > 4'd7) ? 3'd7 : r_cnt[2:0];
  assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_sequencer
// Purpose  : Directed self-checking bench with take/dismiss/return scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [11:0] q_vec [$];
  logic [11:0] q_dis [$];
  logic [11:0] q_ret [$];

  interrupt_sequencer_if bus ();

  interrupt_sequencer #(
    .DEPTH     (2),
    .VEC_BASE  (12'o0100),
    .VEC_SHIFT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_take(input string tag);
    logic [11:0] exp;
    chk1({tag, "_take"}, bus.irq_take, 1'b1);
    exp = (q_vec.size() != 0) ? q_vec.pop_front() : 12'hxxx;
    chk12({tag, "_vec"}, bus.irq_vector, exp);
  endtask

  task automatic check_dismiss(input string tag);
    logic [11:0] exp;
    chk1({tag, "_dismiss"}, bus.ctl_dismiss, 1'b1);
    exp = (q_dis.size() != 0) ? q_dis.pop_front() : 12'hxxx;
    chk12({tag, "_ctl_data"}, bus.ctl_data, exp);
  endtask

  task automatic check_ret(input string tag);
    logic [11:0] exp;
    chk1({tag, "_ret_valid"}, bus.ret_valid, 1'b1);
    exp = (q_ret.size() != 0) ? q_ret.pop_front() : 12'hxxx;
    chk12({tag, "_ret_pc"}, bus.ret_pc, exp);
  endtask

  task automatic check_reset_state(input string tag);
    chk1 ({tag, "_take"},     bus.irq_take,    1'b0);
    chk12({tag, "_vector"},   bus.irq_vector,  12'o0000);
    chk1 ({tag, "_dismiss"},  bus.ctl_dismiss, 1'b0);
    chk12({tag, "_ctl_data"}, bus.ctl_data,    12'o0000);
    chk1 ({tag, "_ret_v"},    bus.ret_valid,   1'b0);
    chk12({tag, "_ret_pc"},   bus.ret_pc,      12'o0000);
    chk1 ({tag, "_ie"},       bus.ie,          1'b0);
    chk12({tag, "_level"},    bus.level,       12'o7777);
    chk12({tag, "_depth"},    {9'd0, bus.depth}, 12'd0);
    chk1 ({tag, "_err"},      bus.err,         1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.next_interrupt = 12'o7777;
    bus.boundary   = 1'b0;
    bus.ie_set     = 1'b0;
    bus.ie_clear   = 1'b0;
    bus.cpu_ack    = 1'b0;
    bus.pc_in      = 12'o0000;
    bus.ret_strobe = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // First take: id 2, vector 0104, id frozen while next_interrupt moves
    bus.ie_set = 1'b1;
    tick();
    bus.ie_set = 1'b0;
    chk1("ie_set", bus.ie, 1'b1);
    bus.next_interrupt = 12'o0002;
    bus.boundary = 1'b1;
    q_vec.push_back(12'o0104);
    tick();
    check_take("take_id2");
    bus.boundary = 1'b0;
    bus.next_interrupt = 12'o0003;
    tick();
    chk1("req_hold_take", bus.irq_take, 1'b1);
    chk12("req_hold_vec", bus.irq_vector, 12'o0104);
    bus.cpu_ack = 1'b1;
    bus.pc_in = 12'o1234;
    q_dis.push_back(12'o0002);
    tick();
    bus.cpu_ack = 1'b0;
    check_dismiss("ack_id2");
    chk12("ack_id2_level", bus.level, 12'o0002);
    chk1("ack_id2_ie", bus.ie, 1'b0);
    chk12("ack_id2_depth", {9'd0, bus.depth}, 12'd1);
    tick();
    chk1("dismiss_one_cycle", bus.ctl_dismiss, 1'b0);

    // Priority: lower priority and equal priority are refused, higher nests
    bus.ie_set = 1'b1;
    tick();
    bus.ie_set = 1'b0;
    bus.boundary = 1'b1;
    bus.next_interrupt = 12'o0003;
    tick();
    tick();
    chk1("lower_prio", bus.irq_take, 1'b0);
    bus.next_interrupt = 12'o0002;
    tick();
    tick();
    chk1("equal_prio", bus.irq_take, 1'b0);
    bus.next_interrupt = 12'o0000;
    q_vec.push_back(12'o0100);
    tick();
    check_take("take_id0");
    bus.boundary = 1'b0;
    bus.cpu_ack = 1'b1;
    bus.pc_in = 12'o0555;
    q_dis.push_back(12'o0000);
    tick();
    bus.cpu_ack = 1'b0;
    check_dismiss("ack_id0");
    chk12("nest_depth", {9'd0, bus.depth}, 12'd2);
    chk12("nest_level", bus.level, 12'o0000);
    tick();

    // Return restores level 2 and re-enables
    bus.ret_strobe = 1'b1;
    q_ret.push_back(12'o0555);
    tick();
    bus.ret_strobe = 1'b0;
    check_ret("ret_id0");
    chk12("ret_id0_level", bus.level, 12'o0002);
    chk12("ret_id0_depth", {9'd0, bus.depth}, 12'd1);
    chk1("ret_id0_ie", bus.ie, 1'b1);

    // Fill the 2-deep stack with id 1
    bus.next_interrupt = 12'o0001;
    bus.boundary = 1'b1;
    q_vec.push_back(12'o0102);
    tick();
    check_take("take_id1");
    bus.boundary = 1'b0;
    bus.cpu_ack = 1'b1;
    bus.pc_in = 12'o0666;
    q_dis.push_back(12'o0001);
    tick();
    bus.cpu_ack = 1'b0;
    check_dismiss("ack_id1");
    chk12("full_depth", {9'd0, bus.depth}, 12'd2);
    tick();

    // Full stack blocks an otherwise eligible id 0
    bus.ie_set = 1'b1;
    tick();
    bus.ie_set = 1'b0;
    bus.next_interrupt = 12'o0000;
    bus.boundary = 1'b1;
    repeat (4) tick();
    chk1("full_block", bus.irq_take, 1'b0);

    // Return and pending take in one cycle: return first, take next cycle
    bus.ret_strobe = 1'b1;
    q_ret.push_back(12'o0666);
    tick();
    bus.ret_strobe = 1'b0;
    check_ret("ret_id1");
    chk1("ret_before_take", bus.irq_take, 1'b0);
    chk12("ret_id1_level", bus.level, 12'o0002);
    q_vec.push_back(12'o0100);
    tick();
    check_take("take_after_ret");

    // Withdraw with ie_clear, then ack and ie_clear together
    bus.ie_clear = 1'b1;
    tick();
    bus.ie_clear = 1'b0;
    chk1("withdraw_take", bus.irq_take, 1'b0);
    chk12("withdraw_depth", {9'd0, bus.depth}, 12'd1);
    chk1("withdraw_ie", bus.ie, 1'b0);
    bus.ie_set = 1'b1;
    tick();
    bus.ie_set = 1'b0;
    q_vec.push_back(12'o0100);
    tick();
    check_take("retake_id0");
    bus.cpu_ack = 1'b1;
    bus.ie_clear = 1'b1;
    bus.pc_in = 12'o0707;
    q_dis.push_back(12'o0000);
    tick();
    bus.cpu_ack = 1'b0;
    bus.ie_clear = 1'b0;
    bus.boundary = 1'b0;
    bus.next_interrupt = 12'o7777;
    check_dismiss("ack_with_clear");
    chk12("ack_clear_depth", {9'd0, bus.depth}, 12'd2);
    chk12("ack_clear_level", bus.level, 12'o0000);
    tick();

    // Back-to-back returns unwind to the empty stack
    bus.ret_strobe = 1'b1;
    q_ret.push_back(12'o0707);
    tick();
    check_ret("unwind1");
    q_ret.push_back(12'o1234);
    tick();
    bus.ret_strobe = 1'b0;
    check_ret("unwind2");
    chk12("unwind_level", bus.level, 12'o7777);
    chk12("unwind_depth", {9'd0, bus.depth}, 12'd0);
    chk1("unwind_err", bus.err, 1'b0);

    // No pending interrupt never takes
    bus.boundary = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk1("none_no_take", bus.irq_take, 1'b0);
    end

    // Return with empty stack is an error and produces no pulse
    bus.ret_strobe = 1'b1;
    tick();
    bus.ret_strobe = 1'b0;
    chk1("empty_ret_err", bus.err, 1'b1);
    chk1("empty_ret_valid", bus.ret_valid, 1'b0);
    chk12("empty_ret_level", bus.level, 12'o7777);

    // Vector wraps mod 4096, then reset in REQ
    bus.next_interrupt = 12'o7776;
    q_vec.push_back(12'o0074);
    tick();
    check_take("take_wrap");
    rst = 1'b1;
    tick();
    check_reset_state("reset_in_req");
    rst = 1'b0;
    bus.boundary = 1'b0;
    bus.next_interrupt = 12'o7777;

    chk12("sb_vec_empty", 12'(q_vec.size()), 12'd0);
    chk12("sb_dis_empty", 12'(q_dis.size()), 12'd0);
    chk12("sb_ret_empty", 12'(q_ret.size()), 12'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
